// File: rtl/joypad_scanner.sv
// Autonomous multi-pad serial joypad scanner with NES-compatible $4016/$4017 CPU registers.
// Latency: to_cpu is combinational from addr; a scan spans LATCH_CYCLES + CLK_DIV + (BITS-1)*2*CLK_DIV + 1 cycles.
// Backpressure: none; CPU accesses are single-cycle and never wait on the scan FSM.
module joypad_scanner #(
    parameter int NUM_PADS     = 2,
    parameter int BITS         = 8,
    parameter int CLK_DIV      = 6,
    parameter int LATCH_CYCLES = 12,
    parameter int POLL_PERIOD  = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wren,
    input  logic                     rden,
    input  logic [15:0]              addr,
    input  logic                     from_cpu,
    input  logic [NUM_PADS-1:0]      jp_data,
    output logic [NUM_PADS-1:0]      jp_clk,
    output logic                     jp_latch,
    output logic [7:0]               to_cpu,
    output logic [NUM_PADS*BITS-1:0] buttons,
    output logic                     scan_busy
);

    localparam int TMAX = (LATCH_CYCLES > CLK_DIV) ? LATCH_CYCLES : CLK_DIV;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int BW   = $clog2(BITS);

    localparam logic [TW-1:0] LATCH_LAST = TW'(LATCH_CYCLES - 1);
    localparam logic [TW-1:0] DIV_LAST   = TW'(CLK_DIV - 1);
    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_PERIOD - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LATCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CLK_LO = 3'd3;
    localparam logic [2:0] S_CLK_HI = 3'd4;
    localparam logic [2:0] S_COMMIT = 3'd5;

    logic [2:0]          state;
    logic [TW-1:0]       tmr;
    logic [BW-1:0]       bidx;
    logic [PW-1:0]       poll_cnt;
    logic                poll_wrap;
    logic [NUM_PADS-1:0] sync_q1;
    logic [NUM_PADS-1:0] sync_q2;
    logic                sample_en;
    logic                commit;
    logic                strobe;
    logic                cs0;
    logic                cs1;
    logic                rd_shift;
    logic [3:0]          pad_lsb;

    logic [BITS-1:0]     shadow [NUM_PADS];
    logic [BITS-1:0]     btn_q  [NUM_PADS];
    logic [BITS-1:0]     shreg  [NUM_PADS];

    assign cs0       = (addr == 16'h4016);
    assign cs1       = (addr == 16'h4017);
    // A write in the same cycle as a read wins: the read then does not shift.
    assign rd_shift  = rden & ~wren;
    assign poll_wrap = (poll_cnt == POLL_LAST);
    // Bit 0 is taken at the end of SETTLE, later bits at the end of each high phase.
    assign sample_en = ((state == S_SETTLE) || (state == S_CLK_HI)) && (tmr == DIV_LAST);
    assign commit    = (state == S_COMMIT);

    assign jp_latch  = (state == S_LATCH);
    assign jp_clk    = (state == S_CLK_LO) ? '0 : '1;
    assign scan_busy = (state != S_IDLE);

    // Two-flop synchroniser for the asynchronous pad data lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= jp_data;
            sync_q2 <= sync_q1;
        end
    end

    // Free-running poll counter; its wrap kicks off a scan when the FSM is idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (poll_wrap) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Scan sequencer: latch pulse, settle, then BITS-1 clock low/high pairs, then commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tmr   <= '0;
            bidx  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (poll_wrap) begin
                        state <= S_LATCH;
                        tmr   <= '0;
                        bidx  <= '0;
                    end
                end
                S_LATCH: begin
                    if (tmr == LATCH_LAST) begin
                        state <= S_SETTLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (tmr == DIV_LAST) begin
                        state <= S_CLK_LO;
                        tmr   <= '0;
                        bidx  <= bidx + 1'b1;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_CLK_LO: begin
                    if (tmr == DIV_LAST) begin
                        state <= S_CLK_HI;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_CLK_HI: begin
                    if (tmr == DIV_LAST) begin
                        tmr <= '0;
                        if (bidx == BIT_LAST) begin
                            state <= S_COMMIT;
                        end else begin
                            state <= S_CLK_LO;
                            bidx  <= bidx + 1'b1;
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                S_COMMIT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // CPU strobe register; $4017 writes belong to the APU frame counter and are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe <= 1'b0;
        end else if (wren && cs0) begin
            strobe <= from_cpu;
        end
    end

    generate
        for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
            // Even pads sit behind $4016, odd pads behind $4017.
            logic pad_sel;
            assign pad_sel = ((g % 2) == 1) ? cs1 : cs0;

            // Shadow capture of each bit as it is shifted out; pad data is active-low.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shadow[g] <= '0;
                end else if (sample_en) begin
                    shadow[g][bidx] <= ~sync_q2[g];
                end
            end

            // Snapshot updates in one cycle so software never sees a half-scanned pad.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    btn_q[g] <= '0;
                end else if (commit) begin
                    btn_q[g] <= shadow[g];
                end
            end

            // CPU shift register: reloaded while strobed (taking a same-cycle commit), else shifts on reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shreg[g] <= '0;
                end else if (strobe) begin
                    shreg[g] <= commit ? shadow[g] : btn_q[g];
                end else if (rd_shift && pad_sel) begin
                    shreg[g] <= {1'b1, shreg[g][BITS-1:1]};
                end
            end

            assign buttons[g*BITS +: BITS] = btn_q[g];
        end

        for (genvar g = 0; g < 4; g++) begin : g_lsb
            if (g < NUM_PADS) begin : g_present
                assign pad_lsb[g] = shreg[g][0];
            end else begin : g_absent
                assign pad_lsb[g] = 1'b0;
            end
        end
    endgenerate

    // Read data: bit6 flags a decoded register, bits 1:0 carry the addressed pads' serial bits.
    always_comb begin
        to_cpu = 8'h00;
        if (cs0) begin
            to_cpu = {1'b0, 1'b1, 4'b0000, pad_lsb[2], pad_lsb[0]};
        end else if (cs1) begin
            to_cpu = {1'b0, 1'b1, 4'b0000, pad_lsb[3], pad_lsb[1]};
        end
    end

endmodule

// File: tb/tb_joypad_scanner.sv
// Directed bench for joypad_scanner: an 8-bit two-pad instance and a 16-bit four-pad instance
// share the clock, reset and CPU bus; behavioural shift-register pads drive active-low data.
module tb_joypad_scanner;

    localparam int P = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic        from_cpu = 1'b0;
    logic [15:0] addr = 16'h0000;

    logic [1:0]  jd1, jc1;
    logic        jl1, bz1;
    logic [7:0]  tc1;
    logic [15:0] bt1;

    logic [3:0]  jd2, jc2;
    logic        jl2, bz2;
    logic [7:0]  tc2;
    logic [63:0] bt2;

    logic [7:0]  pv1 [2];
    logic [7:0]  q1  [2];
    logic [1:0]  pc1 = 2'b11;
    logic [15:0] pv2 [4];
    logic [15:0] q2  [4];
    logic [3:0]  pc2 = 4'hf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    joypad_scanner #(.NUM_PADS(2), .BITS(8), .CLK_DIV(6), .LATCH_CYCLES(12), .POLL_PERIOD(P)) u1 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .rden(rden), .addr(addr), .from_cpu(from_cpu),
        .jp_data(jd1), .jp_clk(jc1), .jp_latch(jl1), .to_cpu(tc1), .buttons(bt1), .scan_busy(bz1)
    );

    joypad_scanner #(.NUM_PADS(4), .BITS(16), .CLK_DIV(6), .LATCH_CYCLES(12), .POLL_PERIOD(P)) u2 (
        .clk(clk), .rst_n(rst_n), .wren(wren), .rden(rden), .addr(addr), .from_cpu(from_cpu),
        .jp_data(jd2), .jp_clk(jc2), .jp_latch(jl2), .to_cpu(tc2), .buttons(bt2), .scan_busy(bz2)
    );

    // Pad models: parallel load while latch is high, shift on each rising pad clock.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (jl1) q1[i] <= pv1[i];
            else if (jc1[i] && !pc1[i]) q1[i] <= q1[i] >> 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (jl2) q2[i] <= pv2[i];
            else if (jc2[i] && !pc2[i]) q2[i] <= q2[i] >> 1;
        end
        pc1 <= jc1;
        pc2 <= jc2;
    end

    always_comb begin
        for (int i = 0; i < 2; i++) jd1[i] = ~q1[i][0];
        for (int i = 0; i < 4; i++) jd2[i] = ~q2[i][0];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic d);
        @(posedge clk); #1;
        addr = a; from_cpu = d; wren = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0; addr = 16'h0000; from_cpu = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [7:0] r1, output logic [7:0] r2);
        @(posedge clk); #1;
        addr = a; rden = 1'b1;
        @(negedge clk);
        r1 = tc1; r2 = tc2;
        @(posedge clk); #1;
        rden = 1'b0; addr = 16'h0000;
    endtask

    task automatic wait_latch1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (jl1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_idle(input bit second, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (!(second ? bz2 : bz1)) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        bit ok;
        int n, run, pulses, badlen, skew, bad;
        logic [7:0] r1, r2;
        logic [7:0] seq [9];
        logic [7:0] e;

        seq = '{8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40, 8'h41};
        pv1[0] = 8'h41; pv1[1] = 8'h80;
        pv2[0] = 16'h0000; pv2[1] = 16'h0000; pv2[2] = 16'h0000; pv2[3] = 16'h0001;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_buttons", bt1, 16'h0000);
        check("rst_jp_clk", jc1, 2'b11);
        check("rst_jp_latch", jl1, 1'b0);
        check("rst_busy", bz1, 1'b0);
        check("rst_to_cpu_noaddr", tc1, 8'h00);
        addr = 16'h4016;
        #1 check("rst_to_cpu_4016", tc1, 8'h40);
        addr = 16'h0000;
        @(posedge clk); #1 rst_n = 1'b1;

        // First scan: latch width, clock pulses, snapshot
        wait_latch1(ok);
        check("latch_seen", ok, 1'b1);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!jl1) break;
            n++;
        end
        check("latch_len", n, 12);
        run = 0; pulses = 0; badlen = 0; skew = 0;
        for (int i = 0; i < 400; i++) begin
            if (jc1[0] !== jc1[1]) skew++;
            if (!jc1[0]) run++;
            else if (run != 0) begin
                pulses++;
                if (run != 6) badlen++;
                run = 0;
            end
            if (!bz1) break;
            @(negedge clk);
        end
        check("scan_done", bz1, 1'b0);
        check("clk_pulses", pulses, 7);
        check("clk_pulse_len", badlen, 0);
        check("clk_skew", skew, 0);
        check("buttons_scan1", bt1, 16'h8041);

        // Serial readout of pad0 with fill-with-1 after 8 reads
        cpu_write(16'h4016, 1'b1);
        cpu_write(16'h4016, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cpu_read(16'h4016, r1, r2);
            check($sformatf("rd4016_%0d", k + 1), r1, seq[k]);
        end

        // Simultaneous read and write: no shift
        cpu_write(16'h4016, 1'b1);
        cpu_write(16'h4016, 1'b0);
        @(posedge clk); #1;
        addr = 16'h4016; from_cpu = 1'b0; wren = 1'b1; rden = 1'b1;
        @(negedge clk);
        check("rw_same_data", tc1, 8'h41);
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0; addr = 16'h0000;
        cpu_read(16'h4016, r1, r2);
        check("rw_noshift_rd1", r1, 8'h41);
        cpu_read(16'h4016, r1, r2);
        check("rw_noshift_rd2", r1, 8'h40);

        // Strobe held: $4017 reads return A without shifting
        pv1[1] = 8'h81;
        wait_latch1(ok);
        wait_idle(1'b0, ok);
        check("scan2_done", ok, 1'b1);
        check("buttons_scan2", bt1, 16'h8141);
        cpu_write(16'h4016, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cpu_read(16'h4017, r1, r2);
            check($sformatf("strobe_rd4017_%0d", k + 1), r1, 8'h41);
        end
        cpu_write(16'h4016, 1'b0);
        cpu_read(16'h4017, r1, r2);
        check("rel_rd4017_1", r1, 8'h41);
        cpu_read(16'h4017, r1, r2);
        check("rel_rd4017_2", r1, 8'h40);

        // Pad change during a scan with strobe high: atomic commit, same-cycle shift reg reload
        cpu_write(16'h4016, 1'b1);
        @(posedge clk); #1 addr = 16'h4016;
        wait_latch1(ok);
        check("scan3_latch", ok, 1'b1);
        pv1[0] = 8'h40;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!bz1) break;
            if (bt1 !== 16'h8141 || tc1 !== 8'h41) bad++;
        end
        check("scan3_stable", bad, 0);
        check("scan3_done", bz1, 1'b0);
        check("scan3_buttons", bt1, 16'h8140);
        check("scan3_shreg", tc1, 8'h40);
        addr = 16'h0000;
        cpu_write(16'h4016, 1'b0);

        // 16-bit four-pad instance: pad3 on bit1 of $4017, fill-with-1 after 16 reads
        wait_idle(1'b1, ok);
        check("u2_idle", ok, 1'b1);
        check("u2_buttons", bt2, 64'h0001_0000_0000_0000);
        cpu_write(16'h4016, 1'b1);
        cpu_write(16'h4016, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            cpu_read(16'h4017, r1, r2);
            e = (k == 1) ? 8'h42 : ((k <= 16) ? 8'h40 : 8'h43);
            check($sformatf("u2_rd4017_%0d", k), r2, e);
        end

        // Reset during CLK_LO
        ok = 1'b0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (jc1[0] == 1'b0) begin ok = 1'b1; break; end
        end
        check("clk_lo_seen", ok, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_jp_clk", jc1, 2'b11);
        check("midrst_jp_latch", jl1, 1'b0);
        check("midrst_buttons", bt1, 16'h0000);
        check("midrst_busy", bz1, 1'b0);
        check("midrst_u2_jp_clk", jc2, 4'hf);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 2 * P; i++) begin
            @(negedge clk);
            if (jl1) break;
            n++;
        end
        check("post_rst_latch_delay", n, P);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/joypad_scanner.md
Name: joypad_scanner

Overview:
- Autonomous serial game-pad controller; successor to the single-strobe joypad interface.
- Periodically scans up to four shift-register pads (NES 8-bit or SNES 16-bit) with its own latch and clock timing, and keeps an atomic button snapshot.
- Presents NES-compatible CPU registers at $4016/$4017, so CPU reads never stall on pad timing.
- Sits on the APU register bus beside the CPU.

Parameters:
- NUM_PADS, 2, physical pads scanned; legal values 1..4.
- BITS, 8, bits shifted per pad per scan; 8 or 16.
- CLK_DIV, 6, clk cycles per jp_clk half-period; minimum 3.
- LATCH_CYCLES, 12, clk cycles jp_latch is held high per scan.
- POLL_PERIOD, 100000, clk cycles from one scan start to the next; must exceed scan length.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wren  in  1  CPU write strobe, one cycle per access
- rden  in  1  CPU read strobe, one cycle per access
- addr  in  16  CPU address
- from_cpu  in  1  CPU data bit0 on writes
- jp_data  in  NUM_PADS  pad serial data, active-low, asynchronous
- jp_clk  out  NUM_PADS  pad shift clocks, idle high
- jp_latch  out  1  pad parallel-load strobe
- to_cpu  out  8  read data
- buttons  out  NUM_PADS*BITS  snapshot, 1 = pressed; pad i occupies [i*BITS +: BITS]; bit0 = first shifted (A)
- scan_busy  out  1  high while the scan FSM is not in IDLE

Behaviour:
- Reset: jp_latch=0, jp_clk=all 1, buttons=0, scan_busy=0, CPU shift regs=0, strobe=0, poll counter=0, FSM=IDLE.
- jp_data passes through a 2-flop synchroniser; the sampled value is inverted before storage.
- Poll counter counts 0..POLL_PERIOD-1 and wraps. At wrap, IDLE goes to LATCH. A wrap occurring while not in IDLE is ignored.
- LATCH: jp_latch=1 for LATCH_CYCLES cycles, then go to SETTLE.
- SETTLE: jp_latch=0; wait CLK_DIV cycles; sample bit0 of all pads into shadow regs; go to CLK_LO.
- CLK_LO: jp_clk=0 for CLK_DIV cycles, then go to CLK_HI.
- CLK_HI: jp_clk=1 for CLK_DIV cycles; on the last cycle, sample the next bit index.
- After bit BITS-1 is sampled: copy shadow to buttons in one cycle (atomic), then return to IDLE.
- Total scan length = LATCH_CYCLES + CLK_DIV + (BITS-1)*2*CLK_DIV (+1 commit cycle).
- All jp_clk bits toggle together.
- Decode: cs0 = addr==$4016, cs1 = addr==$4017.
- Write with wren & cs0: strobe <= from_cpu. Writes to $4017 are ignored (APU frame counter).
- Strobe high: every cycle, CPU shift reg i is loaded from buttons pad i. If a snapshot commit happens in the same cycle, the new snapshot is loaded.
- Pad routing: $4016 reads pad0 (bit0) and pad2 (bit1); $4017 reads pad1 (bit0) and pad3 (bit1). Absent pads read 0.
- to_cpu = {1'b0, cs0|cs1, 4'b0, d1, d0}.
  - d0/d1 are the LSBs of the addressed pads' shift regs.
  - All fields are 0 when neither cs0 nor cs1 is asserted.
  - to_cpu is combinational from addr and registered state.
- Read with rden & csN & strobe low: the addressed pads' shift regs shift right one bit, filling with 1. After BITS reads, reads return 1 (official-pad behaviour).
- Read with strobe high: no shift; returns current button A.
- Read and write in the same cycle: the write takes effect and no shift occurs.
- The CPU path never waits on the FSM; reads during a scan see the previous snapshot.
- Reset asserted mid-scan: all state returns to reset values immediately (jp_latch low, jp_clk high). The scan restarts after the next full POLL_PERIOD.

Test Plan:
- Reset, then bench pad models drive pad0=$41 and pad1=$80 (1=pressed, driven active-low). Wait one scan. Expected: buttons=$8041; jp_latch high exactly 12 cycles; 7 jp_clk low pulses of 6 cycles each.
- Write $4016=1 then $4016=0, then issue 9 rden reads at $4016. Expected to_cpu sequence: $41,$40,$40,$40,$40,$40,$41,$40,$41; the 9th read returns $41.
- Hold strobe=1 and issue 3 reads at $4017 with pad1 A pressed. Expected: each read returns $41 with no shift. Then release strobe; the first read returns $41, the second $40.
- BITS=16, NUM_PADS=4, pad3=$0001. Expected: read 1 at $4017 returns $42 (bit1 set); reads 17 and beyond return $43.
- A pad change is applied mid-scan while strobe=1. Expected: buttons changes only in the single commit cycle; the CPU shift reg picks up the new value that same cycle.
- Assert rst_n low during CLK_LO. Expected: jp_clk is all 1s, jp_latch is 0, buttons is 0 and scan_busy is 0 before the next clk edge; no jp_latch pulse occurs until POLL_PERIOD cycles after rst_n releases.
